// File: rtl/alu_seq_if.sv
// Bus bundle between the control unit, the multi-byte ALU sequencer, the shared ALU and the data memory.
// Optional ALU_SEQ_MEM_WAIT_EN adds the mem_ready back-pressure signal.
interface alu_seq_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) ();
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              cin;
  logic              busy;
  logic              done;
  logic              cout;
  logic              zero;
  logic              pari;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic              mem_wr_en;
  logic [7:0]        mem_wdata;
`ifdef ALU_SEQ_MEM_WAIT_EN
  logic              mem_ready;
`endif

  logic [2:0]        alu_cmd;
  logic [7:0]        alu_inA;
  logic [7:0]        alu_inB;
  logic              alu_sc_i;
  logic [7:0]        alu_rslt;
  logic              alu_sc_o;

  // Environment side: requester, memory and ALU.
  modport master (
`ifdef ALU_SEQ_MEM_WAIT_EN
    output mem_ready,
`endif
    output start, op, src_a, src_b, dst, len, cin,
    input  busy, done, cout, zero, pari,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata,
    input  alu_cmd, alu_inA, alu_inB, alu_sc_i,
    output alu_rslt, alu_sc_o
  );

  // Sequencer side.
  modport slave (
`ifdef ALU_SEQ_MEM_WAIT_EN
    input  mem_ready,
`endif
    input  start, op, src_a, src_b, dst, len, cin,
    output busy, done, cout, zero, pari,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata,
    output alu_cmd, alu_inA, alu_inB, alu_sc_i,
    input  alu_rslt, alu_sc_o
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-byte ALU sequencer: streams operand bytes from memory through the 8-bit ALU and writes results back.
// Define ALU_SEQ_MEM_WAIT_EN to honour mem_ready stalls on every memory cycle.
module alu_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        op_r;
  logic [ADDR_W-1:0] src_a_r, src_b_r, dst_r;
  logic [LEN_W-1:0]  len_r, step;
  logic              carry, zero_r, pari_r, rd_vld;
  logic [7:0]        a_reg, b_reg;

  logic              ready, is_shift, last;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] idx_ext;
  logic [7:0]        op_a, op_b;

`ifdef ALU_SEQ_MEM_WAIT_EN
  assign ready = bus.mem_ready;
`else
  assign ready = 1'b1;
`endif

  assign is_shift = (op_r == OP_SHL) || (op_r == OP_SHR);
  // step always counts up; SHR mirrors it so the most significant byte goes first.
  assign idx      = (op_r == OP_SHR) ? (len_r - step - LEN_W'(1)) : step;
  assign idx_ext  = ADDR_W'(idx);
  assign last     = (step == len_r - LEN_W'(1));

  // Read data is live only in the cycle after an accepted strobe; afterwards the captured copy is used.
  assign op_a = (is_shift && rd_vld) ? bus.mem_rdata : a_reg;
  assign op_b = is_shift ? 8'h00 : (rd_vld ? bus.mem_rdata : b_reg);

  assign bus.cout = carry;
  assign bus.zero = zero_r;
  assign bus.pari = pari_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = 8'h00;
    bus.alu_cmd   = 3'b000;
    bus.alu_inA   = 8'h00;
    bus.alu_inB   = 8'h00;
    bus.alu_sc_i  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = (bus.len == '0) ? S_DONE : S_RD_A;
      end
      S_RD_A: begin
        bus.busy      = 1'b1;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = src_a_r + idx_ext;
        if (ready) state_nxt = is_shift ? S_EXEC : S_RD_B;
      end
      S_RD_B: begin
        bus.busy      = 1'b1;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = src_b_r + idx_ext;
        if (ready) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        bus.busy      = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = dst_r + idx_ext;
        bus.mem_wdata = bus.alu_rslt;
        bus.alu_cmd   = {1'b0, op_r};
        bus.alu_inA   = op_a;
        bus.alu_inB   = op_b;
        bus.alu_sc_i  = carry;
        if (ready) state_nxt = last ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r    <= 2'b00;
      src_a_r <= '0;
      src_b_r <= '0;
      dst_r   <= '0;
      len_r   <= '0;
      step    <= '0;
      carry   <= 1'b0;
      zero_r  <= 1'b0;
      pari_r  <= 1'b0;
      rd_vld  <= 1'b0;
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
    end else begin
      rd_vld <= ready && ((state == S_RD_A) || (state == S_RD_B));
      if (rd_vld) begin
        if (state == S_RD_B)     a_reg <= bus.mem_rdata;
        else if (state == S_EXEC) begin
          if (is_shift) a_reg <= bus.mem_rdata;
          else          b_reg <= bus.mem_rdata;
        end
      end
      if (state == S_IDLE && bus.start) begin
        op_r    <= bus.op;
        src_a_r <= bus.src_a;
        src_b_r <= bus.src_b;
        dst_r   <= bus.dst;
        len_r   <= bus.len;
        step    <= '0;
        carry   <= bus.cin;
        zero_r  <= 1'b1;
        pari_r  <= 1'b0;
      end else if (state == S_EXEC && ready) begin
        // NAND has no meaningful carry chain, so the chain is cleared rather than left to the ALU.
        carry  <= (op_r == OP_NAND) ? 1'b0 : bus.alu_sc_o;
        zero_r <= zero_r & (bus.alu_rslt == 8'h00);
        pari_r <= pari_r ^ (^bus.alu_rslt);
        step   <= step + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: byte memory and 8-bit ALU models, hand-computed results, latencies and strobe counts.
module tb_alu_seq;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();
  alu_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] mem [256];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;

  always @(posedge clk) begin
    if (pl_en)              mem[pl_addr]      <= pl_data;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en)      bus.mem_rdata     <= mem[bus.mem_addr];
  end

  // External ALU: ADD with carry, SHL/SHR through sc, NAND without carry.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum      = {1'b0, bus.alu_inA} + {1'b0, bus.alu_inB} + {8'h00, bus.alu_sc_i};
    bus.alu_rslt = 8'h00;
    bus.alu_sc_o = 1'b0;
    case (bus.alu_cmd)
      3'b000: begin bus.alu_rslt = alu_sum[7:0];                     bus.alu_sc_o = alu_sum[8];     end
      3'b001: begin bus.alu_rslt = {bus.alu_inA[6:0], bus.alu_sc_i}; bus.alu_sc_o = bus.alu_inA[7]; end
      3'b010: begin bus.alu_rslt = {bus.alu_sc_i, bus.alu_inA[7:1]}; bus.alu_sc_o = bus.alu_inA[0]; end
      3'b011: begin bus.alu_rslt = ~(bus.alu_inA & bus.alu_inB);     bus.alu_sc_o = 1'b0;           end
      default: ;
    endcase
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, {bus.busy, bus.done, bus.cout, bus.zero, bus.pari, bus.mem_rd_en, bus.mem_wr_en}, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_alu"}, {bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i, bus.mem_wdata}, 0);
  endtask

  // Issues one command and counts clocks (start edge = clock 1) until done; poke_at re-pulses start mid-run.
  task automatic run_cmd(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                         input logic [3:0] l, input logic ci, input int poke_at,
                         output int lat, output int rds, output int wrs, output int bsy, output int first_wr);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b; bus.dst = d; bus.len = l; bus.cin = ci;
    lat = 0; rds = 0; wrs = 0; bsy = 0; first_wr = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == poke_at) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.len = 4'd9; bus.cin = ~ci; bus.dst = 8'hC0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.mem_rd_en) rds++;
      if (bus.mem_wr_en) begin
        if (first_wr < 0) first_wr = int'(bus.mem_addr);
        wrs++;
      end
      if (bus.busy) bsy++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("done_pulse", {bus.done, bus.busy}, 0);
  endtask

  int lat, rds, wrs, bsy, fw, wr_seen;

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 8'h00; bus.src_b = 8'h00;
    bus.dst = 8'h00; bus.len = 4'd0; bus.cin = 1'b0;
`ifdef ALU_SEQ_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    // ADD, two bytes, carry ripples from byte 0 into byte 1.
    load(8'h10, 8'hFF); load(8'h11, 8'h01); load(8'h20, 8'h01); load(8'h21, 8'h00);
    run_cmd(2'b00, 8'h10, 8'h20, 8'h30, 4'd2, 1'b0, 0, lat, rds, wrs, bsy, fw);
    check("add2_lat", lat, 7);
    check("add2_strobes", {rds[7:0], wrs[7:0], bsy[7:0]}, {8'd4, 8'd2, 8'd6});
    check("add2_mem", {mem[8'h30], mem[8'h31]}, 16'h0002);
    check("add2_flags", {bus.cout, bus.zero, bus.pari}, 3'b001);

    // ADD, one byte with carry-in; start re-pulsed while busy must be ignored.
    load(8'h12, 8'hFF); load(8'h22, 8'h00); load(8'hC0, 8'h5A);
    run_cmd(2'b00, 8'h12, 8'h22, 8'h32, 4'd1, 1'b1, 1, lat, rds, wrs, bsy, fw);
    check("add1_lat", lat, 4);
    check("add1_mem", mem[8'h32], 8'h00);
    check("add1_flags", {bus.cout, bus.zero, bus.pari}, 3'b110);
    check("busy_start_ignored", {wrs[7:0], mem[8'hC0]}, {8'd1, 8'h5A});

    // SHL in place; src_b never read.
    load(8'h40, 8'h80); load(8'h41, 8'h01);
    run_cmd(2'b01, 8'h40, 8'h20, 8'h40, 4'd2, 1'b1, 0, lat, rds, wrs, bsy, fw);
    check("shl_lat", lat, 5);
    check("shl_strobes", {rds[7:0], wrs[7:0]}, {8'd2, 8'd2});
    check("shl_mem", {mem[8'h40], mem[8'h41]}, 16'h0103);
    check("shl_flags", {bus.cout, bus.zero, bus.pari}, 3'b001);

    // SHR: byte 1 first; 0x8001 >> 1 = 0x4000 with shift-out 1.
    load(8'h50, 8'h01); load(8'h51, 8'h80);
    run_cmd(2'b10, 8'h50, 8'h00, 8'h60, 4'd2, 1'b0, 0, lat, rds, wrs, bsy, fw);
    check("shr_lat", lat, 5);
    check("shr_first_wr", fw, 32'h61);
    check("shr_mem", {mem[8'h60], mem[8'h61]}, 16'h0040);
    check("shr_flags", {bus.cout, bus.zero, bus.pari}, 3'b101);

    // ADD across the address wrap: A at FF,00; result at FE,FF overwrites A byte 0 after its read.
    load(8'hFF, 8'h01); load(8'h00, 8'h02); load(8'h24, 8'hFF); load(8'h25, 8'h00);
    run_cmd(2'b00, 8'hFF, 8'h24, 8'hFE, 4'd2, 1'b0, 0, lat, rds, wrs, bsy, fw);
    check("wrap_mem", {mem[8'hFE], mem[8'hFF]}, 16'h0003);
    check("wrap_flags", {bus.cout, bus.zero, bus.pari}, 3'b000);

    // Reset during EXEC of byte 0 of a 3-byte ADD.
    load(8'h70, 8'h11); load(8'h71, 8'h22); load(8'h72, 8'h33);
    load(8'h80, 8'h01); load(8'h81, 8'h01); load(8'h82, 8'h01); load(8'h90, 8'hAA);
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 8'h70; bus.src_b = 8'h80;
    bus.dst = 8'h90; bus.len = 4'd3; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_exec", {bus.mem_wr_en, bus.mem_addr, bus.mem_wdata}, {1'b1, 8'h90, 8'h12});
    reset = 1'b1;
    #1;
    check_quiet("rst_mid");
    wr_seen = 0;
    repeat (2) begin @(negedge clk); wr_seen += int'(bus.mem_wr_en); end
    reset = 1'b0;
    repeat (3) begin @(negedge clk); wr_seen += int'(bus.mem_wr_en); end
    check("rst_no_wr", wr_seen, 0);
    check("rst_mem_kept", mem[8'h90], 8'hAA);

    // NAND after reset; carry-in 1 must not leak into cout.
    load(8'h13, 8'hF0); load(8'h23, 8'hFF);
    run_cmd(2'b11, 8'h13, 8'h23, 8'h33, 4'd1, 1'b1, 0, lat, rds, wrs, bsy, fw);
    check("nand_lat", lat, 4);
    check("nand_mem", mem[8'h33], 8'h0F);
    check("nand_flags", {bus.cout, bus.zero, bus.pari}, 3'b000);

    // Zero length: done next cycle, no memory traffic, flags straight from the command.
    run_cmd(2'b00, 8'h10, 8'h20, 8'h30, 4'd0, 1'b1, 0, lat, rds, wrs, bsy, fw);
    check("len0_lat", lat, 1);
    check("len0_strobes", {rds[7:0], wrs[7:0], bsy[7:0]}, 0);
    check("len0_flags", {bus.cout, bus.zero, bus.pari}, 3'b110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
